// File: rtl/sort_serializer_pkg.sv
`default_nettype none
// ============================================================================
// Module      : sort_serializer_pkg
// Description : Shared sort definitions: index width helper and FSM encoding.
// Revision    : 1.0 - initial release
// ============================================================================
package sort_serializer_pkg;

    localparam int DEF_N = 8;
    localparam int DEF_K = 8;

    localparam logic [0:0] c_ST_IDLE   = 1'b0;
    localparam logic [0:0] c_ST_STREAM = 1'b1;

    // Index width for an N-element vector; never narrower than one bit.
    function automatic int idx_w(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage : sort_serializer_pkg
`default_nettype wire

// File: rtl/sort_serializer_if.sv
`default_nettype none
// ============================================================================
// Module      : sort_serializer_if
// Description : Vector-in / element-out handshake bundle for sort_serializer.
// Revision    : 1.0 - initial release
// ============================================================================
interface sort_serializer_if
    import sort_serializer_pkg::*;
#(
    parameter int N = DEF_N,
    parameter int K = DEF_K
);

    logic [N*K-1:0]      in_data;
    logic                in_valid;
    logic                in_ready;
    logic [K-1:0]        out_data;
    logic                out_valid;
    logic                out_ready;
    logic                out_last;
    logic [idx_w(N)-1:0] out_idx;
    logic                order_err;
    logic                clr_err;

    modport master (
        output in_data, in_valid, out_ready, clr_err,
        input  in_ready, out_data, out_valid, out_last, out_idx, order_err
    );

    modport slave (
        input  in_data, in_valid, out_ready, clr_err,
        output in_ready, out_data, out_valid, out_last, out_idx, order_err
    );

endinterface : sort_serializer_if
`default_nettype wire

// File: rtl/sort_serializer.sv
`default_nettype none
// ============================================================================
// Module      : sort_serializer
// Description : Captures a sorted N-element vector and emits it one element
//               per transfer, flagging any sortedness violation it observes.
// Revision    : 1.0 - initial release
// ============================================================================
module sort_serializer
    import sort_serializer_pkg::*;
#(
    parameter int N       = DEF_N,
    parameter int K       = DEF_K,
    parameter int DESCEND = 0
) (
    input  wire logic         clk,
    input  wire logic         rstn,
    sort_serializer_if.slave  bus
);

    localparam int            IW         = idx_w(N);
    localparam logic [IW-1:0] c_IDX_LAST = IW'(N - 1);
    localparam logic [IW-1:0] c_IDX_ONE  = IW'(1);

    logic [0:0]     r_state;
    logic [IW-1:0]  r_idx;
    logic [N*K-1:0] r_shadow;
    logic [K-1:0]   r_prev;
    logic           r_order_err;

    logic           w_stream;
    logic           w_last;
    logic           w_in_ready;
    logic           w_capture;
    logic           w_xfer;
    logic           w_viol;
    logic [IW-1:0]  w_sel;
    logic [K-1:0]   w_cur;
    logic [K-1:0]   w_elem [N];

    assign w_stream   = (r_state == c_ST_STREAM);
    assign w_last     = w_stream && (r_idx == c_IDX_LAST);
    // Accepting on the last-element cycle gives zero-bubble back-to-back vectors.
    assign w_in_ready = !w_stream || (bus.out_ready && w_last);
    assign w_capture  = bus.in_valid && w_in_ready;
    assign w_xfer     = w_stream && bus.out_ready;

    generate
        for (genvar gi = 0; gi < N; gi++) begin : g_elem
            assign w_elem[gi] = r_shadow[gi*K +: K];
        end
    endgenerate

    assign w_sel = (DESCEND != 0) ? (c_IDX_LAST - r_idx) : r_idx;
    assign w_cur = w_elem[w_sel];

    // idx 0 never compares, so the check cannot span a vector boundary.
    assign w_viol = w_xfer && (r_idx != '0) &&
                    ((DESCEND != 0) ? (w_cur > r_prev) : (w_cur < r_prev));

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state  <= c_ST_IDLE;
            r_idx    <= '0;
            r_shadow <= '0;
        end else if (w_capture) begin
            r_state  <= c_ST_STREAM;
            r_idx    <= '0;
            r_shadow <= bus.in_data;
        end else if (w_xfer) begin
            if (w_last) begin
                r_state <= c_ST_IDLE;
                r_idx   <= '0;
            end else begin
                r_idx   <= r_idx + c_IDX_ONE;
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_prev      <= '0;
            r_order_err <= 1'b0;
        end else begin
            if (w_xfer) begin
                r_prev <= w_cur;
            end
            if (w_viol) begin
                r_order_err <= 1'b1;
            end else if (bus.clr_err) begin
                r_order_err <= 1'b0;
            end
        end
    end

    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = w_stream;
    assign bus.out_data  = w_cur;
    assign bus.out_last  = w_last;
    assign bus.out_idx   = r_idx;
    assign bus.order_err = r_order_err;

endmodule : sort_serializer
`default_nettype wire
